alu_writeback: RTL and testbench

Write-back stage directly downstream of the ALU. It owns the 8×16 general register file, the 8-bit status register and the 12-bit stack pointer. It feeds `rs1data`/`rs2data`, `statusregin` and `stack_reg` to the ALU, and commits the ALU's results on the following clock edge. The 32-bit MULT result is sequenced into a destination register pair, Rd then Rd+1, by a small state machine that stalls upstream.

---
 rtl/alu_writeback.sv | 130 +++++++++++++
 tb/tb_alu_writeback.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Write-back stage behind the ALU: owns the 8x16 register file, the status
// register and the stack pointer, and sequences 32-bit MULT results into Rd/Rd+1.
module alu_writeback #(
    parameter int MULT_LATENCY = 1
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        wb_we,
    input  logic [15:0] instruction,
    input  logic [2:0]  rd_addr,
    input  logic [2:0]  rs1_addr,
    input  logic [2:0]  rs2_addr,
    input  logic [15:0] aluout1,
    input  logic [15:0] aluout2,
    input  logic [7:0]  statusregin,
    input  logic [11:0] stack_in,
    output logic [15:0] rs1data,
    output logic [15:0] rs2data,
    output logic [7:0]  statusreg,
    output logic [11:0] stack_reg,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where wb_valid & wb_ready;
    // wb_ready is high only in IDLE and wb_valid is ignored in every other state.

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_MUL_HI   = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(MULT_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  rd_q, rd_d;
    logic [7:0]  status_q, status_d;
    logic [11:0] stack_q, stack_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];

    logic is_mult;
    logic is_stack;
    logic unused_instr_bits;

    assign is_mult  = (instruction[15:13] == 3'b100);
    assign is_stack = (instruction[15:7]  == 9'b000000011)  // CAR
                    | (instruction[15:12] == 4'b1101)       // CALL
                    | (instruction[15:10] == 6'b011010)     // POP
                    | (instruction[15:4]  == 12'hF00);      // RTN
    assign unused_instr_bits = ^instruction[3:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        status_d = status_q;
        stack_d  = stack_q;
        rf_d     = rf_q;
        unique case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    if (is_mult) begin
                        rd_d    = rd_addr;
                        cnt_d   = LAT;
                        state_d = S_MUL_WAIT;
                    end else begin
                        if (wb_we) begin
                            rf_d[rd_addr] = aluout1;
                        end
                        status_d = statusregin;
                        if (is_stack) begin
                            stack_d = stack_in;
                        end
                    end
                end
            end
            S_MUL_WAIT: begin
                // The product is valid in the last wait cycle; commit the low half then.
                if (cnt_q <= 3'd1) begin
                    rf_d[rd_q] = aluout1;
                    status_d   = statusregin;
                    state_d    = S_MUL_HI;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_MUL_HI: begin
                rf_d[rd_q + 3'd1] = aluout2;
                state_d           = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            rd_q     <= 3'd0;
            status_q <= 8'h00;
            stack_q  <= 12'h000;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            status_q <= status_d;
            stack_q  <= stack_d;
            rf_q     <= rf_d;
        end
    end

    assign rs1data   = rf_q[rs1_addr];
    assign rs2data   = rf_q[rs2_addr];
    assign statusreg = status_q;
    assign stack_reg = stack_q;
    assign wb_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed table, MULT corner sequences on latency-1
// and latency-3 instances, and random transactions against a register-file model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_valid_b;
    logic        wb_we;
    logic [15:0] instruction;
    logic [2:0]  rd_addr, rs1_addr, rs2_addr;
    logic [15:0] aluout1, aluout2;
    logic [7:0]  statusregin;
    logic [11:0] stack_in;

    logic        wb_ready, busy;
    logic [15:0] rs1data, rs2data;
    logic [7:0]  statusreg;
    logic [11:0] stack_reg;
    logic [1:0]  dbg_state;

    logic        b_wb_ready, b_busy;
    logic [15:0] b_rs1data, b_rs2data;
    logic [7:0]  b_statusreg;
    logic [11:0] b_stack_reg;
    logic [1:0]  b_dbg_state;

    always #5 clk = ~clk;

    alu_writeback #(.MULT_LATENCY(1)) u_dut1 (
        .CLOCK(clk), .RESET_N(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_we(wb_we), .instruction(instruction), .rd_addr(rd_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .aluout1(aluout1), .aluout2(aluout2),
        .statusregin(statusregin), .stack_in(stack_in), .rs1data(rs1data),
        .rs2data(rs2data), .statusreg(statusreg), .stack_reg(stack_reg),
        .busy(busy), .dbg_state(dbg_state)
    );

    alu_writeback #(.MULT_LATENCY(3)) u_dut3 (
        .CLOCK(clk), .RESET_N(rst_n), .wb_valid(wb_valid_b), .wb_ready(b_wb_ready),
        .wb_we(wb_we), .instruction(instruction), .rd_addr(rd_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .aluout1(aluout1), .aluout2(aluout2),
        .statusregin(statusregin), .stack_in(stack_in), .rs1data(b_rs1data),
        .rs2data(b_rs2data), .statusreg(b_statusreg), .stack_reg(b_stack_reg),
        .busy(b_busy), .dbg_state(b_dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    logic [15:0] m_rf [8];
    logic [7:0]  m_st;
    logic [11:0] m_stk;

    typedef struct {
        logic        we;
        logic [15:0] instr;
        logic [2:0]  rd;
        logic [15:0] a1;
        logic [7:0]  st;
        logic [11:0] stk;
        logic [15:0] exp_rd;
        logic [7:0]  exp_st;
        logic [11:0] exp_stk;
    } vec_t;

    vec_t tab[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_mult_f(input logic [15:0] i);
        return i[15:13] == 3'b100;
    endfunction

    function automatic bit is_stack_f(input logic [15:0] i);
        return (i[15:7] == 9'b000000011) || (i[15:12] == 4'b1101) ||
               (i[15:10] == 6'b011010) || (i[15:4] == 12'hF00);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 8; a++) m_rf[a] = 16'h0000;
        m_st  = 8'h00;
        m_stk = 12'h000;
    endtask

    task automatic model_commit(input logic we, input logic [15:0] instr, input logic [2:0] rd,
                                input logic [15:0] a1, input logic [15:0] a2,
                                input logic [7:0] st, input logic [11:0] stk);
        if (is_mult_f(instr)) begin
            m_rf[rd] = a1;
            m_rf[(int'(rd) + 1) % 8] = a2;
            m_st = st;
        end else begin
            if (we) m_rf[rd] = a1;
            m_st = st;
            if (is_stack_f(instr)) m_stk = stk;
        end
    endtask

    task automatic drive(input logic we, input logic [15:0] instr, input logic [2:0] rd,
                         input logic [15:0] a1, input logic [15:0] a2,
                         input logic [7:0] st, input logic [11:0] stk);
        wb_we       = we;
        instruction = instr;
        rd_addr     = rd;
        aluout1     = a1;
        aluout2     = a2;
        statusregin = st;
        stack_in    = stk;
    endtask

    // Compare every register, the status register and the stack pointer of the
    // latency-1 instance against the model. Call only with wb_valid low.
    task automatic check_all(input string tag);
        logic [15:0] e;
        for (int a = 0; a < 8; a++) exp_q.push_back(m_rf[a]);
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a);
            rs2_addr = 3'((a + 1) % 8);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s rs1 R%0d", tag, a), rs1data, e);
            check($sformatf("%s rs2 R%0d", tag, (a + 1) % 8), rs2data, m_rf[(a + 1) % 8]);
        end
        check({tag, " statusreg"}, statusreg, m_st);
        check({tag, " stack_reg"}, stack_reg, m_stk);
        check({tag, " wb_ready"}, wb_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int busy_cycles;
        logic [15:0] instr_r;
        logic [2:0]  rd_r;
        logic [15:0] a1_r, a2_r;
        logic [7:0]  st_r;
        logic [11:0] stk_r;
        logic        we_r;

        tab[0] = '{1'b1, 16'h0000, 3'd3, 16'h1234, 8'h01, 12'h111, 16'h1234, 8'h01, 12'h000};
        tab[1] = '{1'b1, 16'h0000, 3'd4, 16'hABCD, 8'h02, 12'h222, 16'hABCD, 8'h02, 12'h000};
        tab[2] = '{1'b0, 16'hD005, 3'd4, 16'hFFFF, 8'h41, 12'h001, 16'hABCD, 8'h41, 12'h001};
        tab[3] = '{1'b1, 16'h0000, 3'd5, 16'h0055, 8'h42, 12'h7FF, 16'h0055, 8'h42, 12'h001};
        tab[4] = '{1'b0, 16'h0180, 3'd0, 16'h9999, 8'h00, 12'h0AB, 16'h0000, 8'h00, 12'h0AB};
        tab[5] = '{1'b1, 16'h6800, 3'd6, 16'hBEEF, 8'h80, 12'h0AC, 16'hBEEF, 8'h80, 12'h0AC};
        tab[6] = '{1'b1, 16'hF003, 3'd7, 16'h7777, 8'h3C, 12'h0AD, 16'h7777, 8'h3C, 12'h0AD};
        tab[7] = '{1'b1, 16'hF010, 3'd1, 16'h0001, 8'h00, 12'h123, 16'h0001, 8'h00, 12'h0AD};
        tab[8] = '{1'b1, 16'h0200, 3'd2, 16'h2222, 8'h11, 12'h456, 16'h2222, 8'h11, 12'h0AD};

        // Clock/reset
        rst_n = 1'b0;
        wb_valid = 1'b0;
        wb_valid_b = 1'b0;
        rs1_addr = 3'd0;
        rs2_addr = 3'd0;
        drive(1'b0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 8'h00, 12'h000);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");
        check("reset busy", busy, 1'b0);

        // Directed table, back-to-back transfers
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            drive(tab[i].we, tab[i].instr, tab[i].rd, tab[i].a1, 16'h0000, tab[i].st, tab[i].stk);
            wb_valid = 1'b1;
            #1;
            check($sformatf("tab%0d wb_ready", i), wb_ready, 1'b1);
            model_commit(tab[i].we, tab[i].instr, tab[i].rd, tab[i].a1, 16'h0000, tab[i].st, tab[i].stk);
            @(negedge clk);
            rs1_addr = tab[i].rd;
            rs2_addr = tab[i].rd;
            #1;
            check($sformatf("tab%0d rs1data", i), rs1data, tab[i].exp_rd);
            check($sformatf("tab%0d rs2data", i), rs2data, tab[i].exp_rd);
            check($sformatf("tab%0d statusreg", i), statusreg, tab[i].exp_st);
            check($sformatf("tab%0d stack_reg", i), stack_reg, tab[i].exp_stk);
        end
        wb_valid = 1'b0;
        check_all("table");

        // MULT into R7 wraps the high half into R0; valid held high through the stall
        @(negedge clk);
        drive(1'b0, 16'h8000, 3'd7, 16'h5678, 16'h0012, 8'h77, 12'hFFF);
        wb_valid = 1'b1;
        #1;
        check("mwrap accept ready", wb_ready, 1'b1);
        @(negedge clk);
        cnt = 0;
        while (!wb_ready && cnt < 10) begin
            cnt++;
            if (cnt == 2) begin
                rs1_addr = 3'd7;
                rs2_addr = 3'd0;
                #1;
                check("mwrap R7 after low edge", rs1data, 16'h5678);
                check("mwrap R0 before high edge", rs2data, 16'h0000);
            end
            @(negedge clk);
        end
        wb_valid = 1'b0;
        check("mwrap stall cycles", cnt, 2);
        model_commit(1'b0, 16'h8000, 3'd7, 16'h5678, 16'h0012, 8'h77, 12'hFFF);
        check_all("mwrap");

        // Latency-3 instance: R5 on the 3rd edge after accept, R6 on the 4th
        @(negedge clk);
        drive(1'b0, 16'h9ABC, 3'd5, 16'h1111, 16'h2222, 8'h5A, 12'h000);
        rs1_addr = 3'd5;
        rs2_addr = 3'd6;
        wb_valid_b = 1'b1;
        @(negedge clk);
        wb_valid_b = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("lat3 R5 k=%0d", k), b_rs1data, (k >= 3) ? 16'h1111 : 16'h0000);
            check($sformatf("lat3 R6 k=%0d", k), b_rs2data, (k >= 4) ? 16'h2222 : 16'h0000);
            check($sformatf("lat3 busy k=%0d", k), b_busy, (k < 4) ? 1'b1 : 1'b0);
            if (b_busy) busy_cycles++;
            @(negedge clk);
        end
        check("lat3 busy cycles", busy_cycles, 4);
        check("lat3 statusreg", b_statusreg, 8'h5A);
        check("lat3 wb_ready", b_wb_ready, 1'b1);

        // Random transactions against the model
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                wb_valid = 1'b0;
                drive(1'b1, 16'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                      8'($urandom), 12'($urandom));
            end
            case ($urandom_range(0, 5))
                0: instr_r = {3'b100, 13'($urandom)};
                1: instr_r = {4'b1101, 12'($urandom)};
                2: instr_r = {6'b011010, 10'($urandom)};
                3: instr_r = {12'hF00, 4'($urandom)};
                4: instr_r = {9'b000000011, 7'($urandom)};
                default: instr_r = 16'($urandom);
            endcase
            we_r  = 1'($urandom);
            rd_r  = 3'($urandom);
            a1_r  = 16'($urandom);
            a2_r  = 16'($urandom);
            st_r  = 8'($urandom);
            stk_r = 12'($urandom);
            @(negedge clk);
            drive(we_r, instr_r, rd_r, a1_r, a2_r, st_r, stk_r);
            wb_valid = 1'b1;
            #1;
            check($sformatf("rnd%0d ready", t), wb_ready, 1'b1);
            @(negedge clk);
            wb_valid = 1'b0;
            cnt = 0;
            while (!wb_ready && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            check($sformatf("rnd%0d stall", t), cnt, is_mult_f(instr_r) ? 2 : 0);
            model_commit(we_r, instr_r, rd_r, a1_r, a2_r, st_r, stk_r);
            check_all($sformatf("rnd%0d", t));
        end

        // Reset during MUL_WAIT discards both pending writes
        @(negedge clk);
        drive(1'b1, 16'h8123, 3'd2, 16'hAAAA, 16'hBBBB, 8'hC3, 12'h005);
        wb_valid = 1'b1;
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        check("rstmul busy before reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmul wb_ready", wb_ready, 1'b1);
        check("rstmul busy", busy, 1'b0);
        rs1_addr = 3'd2;
        rs2_addr = 3'd3;
        #1;
        check("rstmul R2", rs1data, 16'h0000);
        check("rstmul R3", rs2data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        check_all("rstmul after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
